// File: rtl/pixel_combinator.sv
// pixel_combinator
// Consumer end of the per-engine reorder queues. Walks the frame in raster
// order and presents each coordinate on the shared check bus. It then waits
// for an engine queue to report a front-of-queue match, and emits the popped
// colour as a video stream beat carrying SOF (tuser) and EOL (tlast).
//
// Optional feature: define PIXCOMB_WATCHDOG_EN to enable the WAIT watchdog.
// When a coordinate sees no match for TIMEOUT_CYCLES cycles, the block emits
// a black pixel and sets err_timeout. Without the macro, WAIT holds
// indefinitely and err_timeout is tied to 0.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   run               level; permits a frame to start, sampled again only at frame end
//   match_i           per-queue front-of-queue match
//   colour_i          per-queue colour, queue k at [k*RGB_SIZE +: RGB_SIZE]
//   xpixel_check_o    check bus x, all-ones when parked
//   ypixel_check_o    check bus y, all-ones when parked
//   tdata/tvalid/tready/tuser/tlast  video stream toward the frame writer
//   frame_done        1-cycle pulse after the handshake of the last pixel
//   err_multi         sticky: more than one queue matched in WAIT
//   err_timeout       sticky: watchdog fired
//   state_dbg         current FSM state (IDLE=0, WAIT=1, CAPT=2, EMIT=3)
//
// Stream handshake: a beat transfers on a rising edge where tvalid && tready.
// Once tvalid is high, tdata/tuser/tlast hold stable until that transfer.
// tvalid never depends combinationally on tready.
module pixel_combinator #(
  parameter int NUM_ENG        = 4,
  parameter int DATA_WIDTH     = 10,
  parameter int RGB_SIZE       = 24,
  parameter int IMG_W          = 640,
  parameter int IMG_H          = 480,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic [NUM_ENG-1:0]          match_i,
  input  logic [NUM_ENG*RGB_SIZE-1:0] colour_i,
  output logic [DATA_WIDTH-1:0]       xpixel_check_o,
  output logic [DATA_WIDTH-1:0]       ypixel_check_o,
  output logic [RGB_SIZE-1:0]         tdata,
  output logic                        tvalid,
  input  logic                        tready,
  output logic                        tuser,
  output logic                        tlast,
  output logic                        frame_done,
  output logic                        err_multi,
  output logic                        err_timeout,
  output logic [1:0]                  state_dbg
);

  localparam int SEL_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(IMG_W - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT, S_EMIT} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] x, y;
  logic [SEL_W-1:0]      sel, low_idx;
  logic                  any_match, multi_match;
  logic                  handshake, last_x, last_px;
  logic                  wd_fire;

  assign any_match   = |match_i;
  // A value with two or more bits set keeps a bit after clearing its lowest one.
  assign multi_match = (match_i & (match_i - NUM_ENG'(1))) != '0;
  assign handshake   = (state == S_EMIT) && tvalid && tready;
  assign last_x      = (x == X_LAST);
  assign last_px     = last_x && (y == Y_LAST);
  assign state_dbg   = state;

  // The coordinate is visible only in WAIT and CAPT. Parking it elsewhere
  // keeps every queue from popping while there is nowhere to put the colour.
  // It stays driven in CAPT so that the pop on the falling edge after the
  // match lands on colour_i before CAPT samples it.
  assign xpixel_check_o = (state == S_WAIT || state == S_CAPT) ? x : '1;
  assign ypixel_check_o = (state == S_WAIT || state == S_CAPT) ? y : '1;

  // Lowest-index matching queue wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (match_i[i]) low_idx = SEL_W'(i);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (run) state_next = S_WAIT;
      S_WAIT: if (any_match || wd_fire) state_next = S_CAPT;
      S_CAPT: state_next = S_EMIT;
      S_EMIT: if (handshake) state_next = (last_px && !run) ? S_IDLE : S_WAIT;
      default: state_next = S_IDLE;
    endcase
  end

`ifdef PIXCOMB_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic        forced;

  // The counter is held at zero outside WAIT, so it reads zero on entry to WAIT.
  assign wd_fire = (state == S_WAIT) && !any_match &&
                   (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt      <= '0;
      forced      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt <= (state == S_WAIT) ? wd_cnt + 32'd1 : '0;
      if (state == S_WAIT) begin
        if (any_match) begin
          forced <= 1'b0;
        end else if (wd_fire) begin
          forced      <= 1'b1;
          err_timeout <= 1'b1;
        end
      end
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      sel        <= '0;
      tdata      <= '0;
      tvalid     <= 1'b0;
      tuser      <= 1'b0;
      tlast      <= 1'b0;
      frame_done <= 1'b0;
      err_multi  <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= handshake && last_px;
      case (state)
        S_WAIT: begin
          if (any_match) begin
            sel <= low_idx;
            if (multi_match) err_multi <= 1'b1;
          end
        end
        S_CAPT: begin
`ifdef PIXCOMB_WATCHDOG_EN
          tdata <= forced ? '0 : colour_i[sel*RGB_SIZE +: RGB_SIZE];
`else
          tdata <= colour_i[sel*RGB_SIZE +: RGB_SIZE];
`endif
          tvalid <= 1'b1;
          tuser  <= (x == '0) && (y == '0);
          tlast  <= last_x;
        end
        S_EMIT: begin
          if (handshake) begin
            tvalid <= 1'b0;
            if (last_x) begin
              x <= '0;
              y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_combinator.sv
// Directed bench for pixel_combinator on a 4x2 frame.
module tb_pixel_combinator;

  localparam int NUM_ENG = 4;
  localparam int DW      = 10;
  localparam int RGB     = 24;
  localparam int IMG_W   = 4;
  localparam int IMG_H   = 2;
  localparam int TO      = 16;

  localparam int ST_IDLE = 0;
  localparam int ST_WAIT = 1;
  localparam int ST_CAPT = 2;
  localparam int ST_EMIT = 3;

  logic                    clk;
  logic                    reset;
  logic                    run;
  logic [NUM_ENG-1:0]      match_i;
  logic [NUM_ENG*RGB-1:0]  colour_i;
  logic [DW-1:0]           xpixel_check_o, ypixel_check_o;
  logic [RGB-1:0]          tdata;
  logic                    tvalid, tready, tuser, tlast, frame_done;
  logic                    err_multi, err_timeout;
  logic [1:0]              state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int ex = 0;
  int ey = 0;
  int beats = 0;
  int fd_count = 0;
  int park = (1 << DW) - 1;

  pixel_combinator #(
    .NUM_ENG(NUM_ENG), .DATA_WIDTH(DW), .RGB_SIZE(RGB),
    .IMG_W(IMG_W), .IMG_H(IMG_H), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .match_i(match_i), .colour_i(colour_i),
    .xpixel_check_o(xpixel_check_o), .ypixel_check_o(ypixel_check_o),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .tuser(tuser), .tlast(tlast),
    .frame_done(frame_done), .err_multi(err_multi), .err_timeout(err_timeout),
    .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitors for stream beats and frame_done pulses
  always @(posedge clk) if (!reset && tvalid && tready) beats++;
  always @(negedge clk) if (frame_done) fd_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Serve the coordinate the model expects: wait idle_cycles with no match,
  // then raise mask with col in the lowest masked slot and complement data in
  // all other slots. Finally, hold tready low for stall cycles in EMIT.
  task automatic do_pixel(input logic [3:0] mask, input logic [23:0] col,
                          input int idle_cycles, input int stall);
    int  sel;
    logic lx, lp;
    sel = -1;
    for (int k = 0; k < NUM_ENG; k++) if (mask[k] && sel < 0) sel = k;
    lx = (ex == IMG_W - 1);
    lp = lx && (ey == IMG_H - 1);

    chk("wait_state", state_dbg, ST_WAIT);
    chk("check_x", xpixel_check_o, ex);
    chk("check_y", ypixel_check_o, ey);
    if (idle_cycles > 0) begin
      repeat (idle_cycles) tick();
      chk("wait_hold", state_dbg, ST_WAIT);
    end

    match_i  = mask;
    colour_i = {NUM_ENG{~col}};
    colour_i[sel*RGB +: RGB] = col;
    tready   = (stall == 0);
    tick();
    match_i = '0;
    chk("capt_state", state_dbg, ST_CAPT);
    chk("capt_check_x", xpixel_check_o, ex);
    tick();
    colour_i = '0;
    chk("emit_tvalid", tvalid, 1);
    chk("emit_tdata", tdata, col);
    chk("emit_tuser", tuser, (ex == 0 && ey == 0));
    chk("emit_tlast", tlast, lx);
    chk("emit_park_x", xpixel_check_o, park);
    chk("emit_park_y", ypixel_check_o, park);
    for (int s = 0; s < stall; s++) begin
      match_i = 4'b1111;
      tick();
      chk("stall_state", state_dbg, ST_EMIT);
      chk("stall_tvalid", tvalid, 1);
      chk("stall_tdata", tdata, col);
      chk("stall_tuser", tuser, (ex == 0 && ey == 0));
      chk("stall_tlast", tlast, lx);
      chk("stall_park", xpixel_check_o, park);
    end
    match_i = '0;
    tready  = 1'b1;
    tick();
    chk("post_tvalid", tvalid, 0);
    chk("post_frame_done", frame_done, lp);
    if (lx) begin
      ex = 0;
      ey = lp ? 0 : ey + 1;
    end else begin
      ex = ex + 1;
    end
    if (lp && !run) begin
      chk("post_state_idle", state_dbg, ST_IDLE);
      chk("post_park_y", ypixel_check_o, park);
    end else begin
      chk("post_state_wait", state_dbg, ST_WAIT);
      chk("post_next_x", xpixel_check_o, ex);
      chk("post_next_y", ypixel_check_o, ey);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; match_i = '0; colour_i = '0; tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_multi", err_multi, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_park_x", xpixel_check_o, park);
    chk("rst_park_y", ypixel_check_o, park);

    reset = 1'b0;
    tick();
    chk("idle_no_run", state_dbg, ST_IDLE);
    run = 1'b1;
    tick();

    // Line 0
    do_pixel(4'b0100, 24'hFF0000, 0, 0);
    do_pixel(4'b0001, 24'h00FF00, 2, 5);
    chk("err_multi_clear", err_multi, 0);
    do_pixel(4'b0110, 24'h123456, 0, 0);
    chk("err_multi_set", err_multi, 1);
    do_pixel(4'b1000, 24'hABCDEF, 1, 1);

    // Line 1; run drops mid-frame but the frame completes
    run = 1'b0;
    do_pixel(4'b0010, 24'h000001, 0, 2);
    do_pixel(4'b0001, 24'h800000, 3, 0);
    do_pixel(4'b0100, 24'h0F0F0F, 0, 1);
    do_pixel(4'b1000, 24'hFFFFFF, 0, 0);

    tick();
    chk("fd_pulse_end", frame_done, 0);
    chk("idle_after_frame", state_dbg, ST_IDLE);
    chk("idle_park_x", xpixel_check_o, park);
    chk("err_multi_sticky", err_multi, 1);
    chk("beat_count", beats, 8);
    chk("fd_count", fd_count, 1);

    // A coordinate that never matches
    run = 1'b1;
    tick();
    chk("nm_wait", state_dbg, ST_WAIT);
`ifdef PIXCOMB_WATCHDOG_EN
    repeat (TO - 1) tick();
    chk("wd_pre_state", state_dbg, ST_WAIT);
    chk("wd_pre_err", err_timeout, 0);
    tick();
    chk("wd_capt", state_dbg, ST_CAPT);
    chk("wd_err", err_timeout, 1);
    tick();
    chk("wd_tvalid", tvalid, 1);
    chk("wd_tdata", tdata, 0);
    tready = 1'b1;
    tick();
    ex = 1;
    chk("wd_next_x", xpixel_check_o, ex);
    chk("wd_next_y", ypixel_check_o, 0);
`else
    repeat (100) tick();
    chk("nm_still_wait", state_dbg, ST_WAIT);
    chk("nm_check_x", xpixel_check_o, 0);
    chk("nm_check_y", ypixel_check_o, 0);
    chk("nm_err_timeout", err_timeout, 0);
`endif

    // Reset while a beat is stalled in EMIT
    match_i  = 4'b0001;
    colour_i = {NUM_ENG{24'h5A5A5A}};
    tready   = 1'b0;
    tick();
    match_i = '0;
    tick();
    chk("pre_rst_tvalid", tvalid, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_state", state_dbg, ST_IDLE);
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_tdata", tdata, 0);
    chk("mid_rst_err_multi", err_multi, 0);
    chk("mid_rst_park", xpixel_check_o, park);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
